muldiv_hilo: RTL
================

# muldiv_hilo

Multi-cycle multiply/divide unit and owner of the HI/LO register pair, sitting beside the EX-stage ALU. It accepts mult/multu/div/divu launches and direct mthi/mtlo writes from EX. It supplies `hilo_q` back to the ALU for mfhi/mflo. While an operation is in flight, it raises a stall so the pipeline never reads or overwrites HI/LO early.

## Interface
- `MUL_LAT`, 3, multiply latency in clock edges (≥1)
- `clk_cpu`  in  1  CPU clock; all state updates on rising edge
- `reset`  in  1  synchronous, active-high reset
- `start`  in  1  launch op in `op` with operands `rs`/`rt`
- `op`  in  2  00 mult, 01 multu, 10 div, 11 divu
- `rs`  in  32  operand A / dividend
- `rt`  in  32  operand B / divisor
- `wr_en`  in  1  direct HI/LO write (mthi/mtlo), driven by ALU `hilo_wr_en` for those ops
- `wr_data`  in  64  full merged {HI,LO} value from ALU
- `hilo_rd`  in  1  EX instruction is mfhi/mflo
- `flush`  in  1  abort in-flight op (exception/branch kill)
- `hilo_q`  out  64  {HI,LO} register
- `busy`  out  1  operation in flight
- `stall`  out  1  freeze EX and earlier stages
- `done`  out  1  one-cycle pulse: new result visible on `hilo_q`
- `div_zero`  out  1  one-cycle pulse with `done` when a div/divu had `rt`==0

## Operation
- States: IDLE, MUL, DIV_SETUP, DIV_ITER, DIV_FIX.
- IDLE + `start`:
  - Latch `op`, `rs`, `rt`.
  - mult/multu go to MUL with counter = MUL_LAT−1.
  - div/divu go to DIV_SETUP.
- MUL:
  - Product is computed once from the latched operands: signed 32×32→64 for mult, unsigned for multu.
  - Counter decrements each cycle. At 0, write product to HI/LO and return to IDLE.
- DIV_SETUP:
  - Signed: take magnitudes of both operands. Record quotient sign = sign(rs) XOR sign(rt), and remainder sign = sign(rs).
  - Unsigned: use operands as-is.
  - Clear the partial remainder and load the iteration counter with 31.
- DIV_ITER: radix-2 restoring step, one quotient bit per cycle, MSB first, 32 cycles total.
- DIV_FIX:
  - Negate quotient and/or remainder per the recorded signs.
  - Write HI=remainder, LO=quotient, go to IDLE.
- Divide by zero (`rt`==0 at launch):
  - Skip the iterations: DIV_SETUP goes directly to DIV_FIX.
  - Result is HI=`rs`, LO=32'hFFFF_FFFF, with `div_zero` pulsing alongside `done`.
- Overflow case 0x8000_0000 / 0xFFFF_FFFF (div): LO=0x8000_0000, HI=0. No trap.
- `wr_en` in IDLE and `stall` low: `hilo_q` ← `wr_data` at that edge.
- `stall` = `busy` & (`start` | `wr_en` | `hilo_rd`). While stalled, `start` and `wr_en` are ignored; EX re-presents them after `busy` drops.
- `wr_en` and `start` in the same IDLE cycle: both are accepted. The write lands immediately and the op result overwrites it later.
- `flush`: highest priority after reset.
  - Any state goes to IDLE at that edge with HI/LO unchanged and no `done`.
  - `start` in the same cycle as `flush` is dropped.
- `reset`: `hilo_q`=0, `busy`=0, `stall`=0, `done`=0, `div_zero`=0, state IDLE. Applies mid-operation with the same result.

## Timing
- Edge E0 = the edge sampling `start` in IDLE.
- Multiply:
  - `busy`=1 from the cycle after E0 through edge E0+MUL_LAT.
  - `hilo_q` is new and `done`=1 in the cycle after E0+MUL_LAT, with `busy`=0 that cycle.
- Divide:
  - SETUP 1 + ITER 32 + FIX 1 cycles, so the result is visible after E0+34 edges.
  - Divide by zero: visible after E0+2 edges.
- Back-to-back: a new `start` is accepted in the same cycle `done` is high.
- `stall` is combinational from `busy` and inputs. Everything else is registered.

## Structure
- Shared package `muldiv_pkg` holds:
  - the `op` encoding constants (MD_MULT, MD_MULTU, MD_DIV, MD_DIVU);
  - the state enum;
  - DIV_ITERS=32.
- The op encodings sit next to the existing ALU control codes in `defines.v` so that decode maps `R_mult`/`R_div`/… to them.
- One sub-module, `muldiv_div_core`, holds the 32-bit restoring-divide datapath: partial remainder, quotient shift register, iteration counter, and one-step subtract/restore. It has load/step inputs and a last-step output.
- Top level holds the FSM, multiplier, sign fixup, HI/LO register and stall logic.

## Test plan
- mult rs=0xFFFF_FFFD (−3), rt=5: after 3 edges `hilo_q`=0xFFFF_FFFF_FFFF_FFF1 and `done` for 1 cycle.
- multu rs=0xFFFF_FFFF, rt=2: `hilo_q`=0x0000_0001_FFFF_FFFE.
- divu 100/7: HI=2, LO=14, visible exactly 34 edges after start.
- div −7/2: LO=0xFFFF_FFFD, HI=0xFFFF_FFFF. Also div 0x8000_0000/−1: LO=0x8000_0000, HI=0.
- div rs=0x1234, rt=0: after 2 edges HI=0x1234, LO=0xFFFF_FFFF, `div_zero`=1. Also mthi via `wr_en` while a divu is busy: `stall`=1 and HI/LO unchanged until `done`.
- Mid-divide: `flush` at iteration 10 gives IDLE next cycle, `hilo_q` keeps its prior value and there is no `done`. `reset` mid-multiply gives `hilo_q`=0 and `busy`=0 next cycle.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared encodings, state type and helpers for the multiply/divide unit and its HI/LO pair.
package muldiv_pkg;

  localparam logic [1:0] MD_MULT  = 2'b00;
  localparam logic [1:0] MD_MULTU = 2'b01;
  localparam logic [1:0] MD_DIV   = 2'b10;
  localparam logic [1:0] MD_DIVU  = 2'b11;

  localparam int unsigned DIV_ITERS = 32;
  localparam int unsigned DIV_CNT_W = $clog2(DIV_ITERS);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV_SETUP,
    ST_DIV_ITER,
    ST_DIV_FIX
  } md_state_e;

  // Two's-complement negate when neg is set; used for magnitudes and sign fixup.
  function automatic logic [31:0] cond_neg(input logic [31:0] v, input logic neg);
    return neg ? 32'(-v) : v;
  endfunction

endpackage

// File: rtl/muldiv_div_core.sv
// 32-bit radix-2 restoring divider datapath: one quotient bit per step, MSB first.
module muldiv_div_core
  import muldiv_pkg::*;
(
  input  logic        clk_cpu,
  input  logic        reset,
  input  logic        load,
  input  logic        step,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic [31:0] quotient,
  output logic [31:0] remainder,
  output logic        last_c
);

  logic [31:0]          rem_q;
  logic [31:0]          quo_q;
  logic [31:0]          den_q;
  logic [DIV_CNT_W-1:0] cnt_q;

  logic [32:0] shifted;
  logic [33:0] diff;
  logic        fits;

  // Shift next dividend bit into the partial remainder and trial-subtract.
  always_comb begin
    shifted = {rem_q, quo_q[31]};
    diff    = {1'b0, shifted} - {2'b00, den_q};
    fits    = ~diff[33];
  end

  always_ff @(posedge clk_cpu) begin
    if (reset) begin
      rem_q <= '0;
      quo_q <= '0;
      den_q <= '0;
      cnt_q <= '0;
    end else if (load) begin
      rem_q <= '0;
      quo_q <= dividend;
      den_q <= divisor;
      cnt_q <= DIV_CNT_W'(DIV_ITERS - 1);
    end else if (step) begin
      rem_q <= fits ? diff[31:0] : shifted[31:0];
      quo_q <= {quo_q[30:0], fits};
      cnt_q <= cnt_q - DIV_CNT_W'(1);
    end
  end

  assign quotient  = quo_q;
  assign remainder = rem_q;
  assign last_c    = (cnt_q == '0);

endmodule

// File: rtl/muldiv_hilo.sv
// Multi-cycle mult/div unit owning HI/LO; stalls EX while a result is pending.
module muldiv_hilo
  import muldiv_pkg::*;
#(
  parameter int unsigned MUL_LAT = 3
) (
  input  logic        clk_cpu,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] rs,
  input  logic [31:0] rt,
  input  logic        wr_en,
  input  logic [63:0] wr_data,
  input  logic        hilo_rd,
  input  logic        flush,
  output logic [63:0] hilo_q,
  output logic        busy,
  output logic        stall,
  output logic        done,
  output logic        div_zero
);

  localparam int unsigned MCNT_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

  md_state_e         state;
  logic [1:0]        op_q;
  logic [31:0]       a_q;
  logic [31:0]       b_q;
  logic [MCNT_W-1:0] mcnt_q;
  logic              q_neg_q;
  logic              r_neg_q;
  logic              dz_q;

  logic        signed_div;
  logic [63:0] product;
  logic        div_load;
  logic        div_step;
  logic [31:0] div_quo;
  logic [31:0] div_rem;
  logic        div_last;

  // Low 64 bits of the extended product give the exact signed/unsigned result.
  always_comb begin
    signed_div = (op_q == MD_DIV);
    if (op_q == MD_MULT)
      product = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
    else
      product = {32'h0, a_q} * {32'h0, b_q};
    div_load = (state == ST_DIV_SETUP) && !flush;
    div_step = (state == ST_DIV_ITER) && !flush;
  end

  muldiv_div_core u_div_core (
    .clk_cpu   (clk_cpu),
    .reset     (reset),
    .load      (div_load),
    .step      (div_step),
    .dividend  (cond_neg(a_q, signed_div & a_q[31])),
    .divisor   (cond_neg(b_q, signed_div & b_q[31])),
    .quotient  (div_quo),
    .remainder (div_rem),
    .last_c    (div_last)
  );

  always_ff @(posedge clk_cpu) begin
    if (reset) begin
      state    <= ST_IDLE;
      op_q     <= MD_MULT;
      a_q      <= '0;
      b_q      <= '0;
      mcnt_q   <= '0;
      q_neg_q  <= 1'b0;
      r_neg_q  <= 1'b0;
      dz_q     <= 1'b0;
      hilo_q   <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      done     <= 1'b0;
      div_zero <= 1'b0;
      if (flush) begin
        state <= ST_IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (wr_en) hilo_q <= wr_data;
            if (start) begin
              op_q <= op;
              a_q  <= rs;
              b_q  <= rt;
              busy <= 1'b1;
              if (op == MD_MULT || op == MD_MULTU) begin
                mcnt_q <= MCNT_W'(MUL_LAT - 1);
                state  <= ST_MUL;
              end else begin
                state <= ST_DIV_SETUP;
              end
            end
          end
          ST_MUL: begin
            if (mcnt_q == '0) begin
              hilo_q <= product;
              done   <= 1'b1;
              busy   <= 1'b0;
              state  <= ST_IDLE;
            end else begin
              mcnt_q <= mcnt_q - MCNT_W'(1);
            end
          end
          ST_DIV_SETUP: begin
            q_neg_q <= signed_div & (a_q[31] ^ b_q[31]);
            r_neg_q <= signed_div & a_q[31];
            dz_q    <= (b_q == '0);
            state   <= (b_q == '0) ? ST_DIV_FIX : ST_DIV_ITER;
          end
          ST_DIV_ITER: begin
            if (div_last) state <= ST_DIV_FIX;
          end
          ST_DIV_FIX: begin
            if (dz_q)
              hilo_q <= {a_q, 32'hFFFF_FFFF};
            else
              hilo_q <= {cond_neg(div_rem, r_neg_q), cond_neg(div_quo, q_neg_q)};
            done     <= 1'b1;
            div_zero <= dz_q;
            busy     <= 1'b0;
            state    <= ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  assign stall = busy & (start | wr_en | hilo_rd);

endmodule
